// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, sample/coefficient/accumulator types and default biquad taps.
package iir_pkg;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;
  localparam int ACC_W     = 40;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  // Butterworth low-pass, fc = 100 kHz at fs = 10 MHz, Q2.14
  localparam coef_t B0_DEF = 16'sd15;
  localparam coef_t B1_DEF = 16'sd31;
  localparam coef_t B2_DEF = 16'sd15;
  localparam coef_t A1_DEF = -16'sd31313;
  localparam coef_t A2_DEF = 16'sd14991;
endpackage

// File: rtl/iir_df1_biquad_filter_if.sv
// iir_df1_biquad_filter_if: sample stream into and out of the biquad section.
interface iir_df1_biquad_filter_if;
  import iir_pkg::*;
  sample_t din;
  sample_t dout;
  modport master (output din, input dout);
  modport slave  (input din, output dout);
endinterface

// File: rtl/iir_round_sat.sv
// iir_round_sat: round-half-up rescale of a Q.COEF_FRAC accumulator and clamp to the sample range.
module iir_round_sat
  import iir_pkg::*;
(
  input  acc_t    acc_i,
  output sample_t y_o
);
  localparam acc_t HALF = acc_t'(2 ** (COEF_FRAC - 1));
  localparam acc_t MAX  = acc_t'(2 ** (DATA_W - 1) - 1);
  localparam acc_t MIN  = acc_t'(-(2 ** (DATA_W - 1)));
  acc_t sh;
  always_comb begin
    sh  = (acc_i + HALF) >>> COEF_FRAC;
    y_o = sh > MAX ? sample_t'(MAX) : sh < MIN ? sample_t'(MIN) : sample_t'(sh);
  end
endmodule

// File: rtl/iir_df1_biquad_filter.sv
// iir_df1_biquad_filter: Direct Form I biquad, one sample per clock, single-cycle MAC.
module iir_df1_biquad_filter
  import iir_pkg::*;
#(
  parameter coef_t B0 = B0_DEF,
  parameter coef_t B1 = B1_DEF,
  parameter coef_t B2 = B2_DEF,
  parameter coef_t A1 = A1_DEF,
  parameter coef_t A2 = A2_DEF
) (
  input logic                     clk,
  input logic                     rst_n,
  iir_df1_biquad_filter_if.slave  bus
);
  sample_t x1_q, x2_q, y1_q, y2_q, dout_q;
  sample_t y_d;
  acc_t    acc_d;
  function automatic acc_t mul(sample_t s, coef_t c);
    return acc_t'(s) * acc_t'(c);
  endfunction
  // feedback taps use the already-saturated outputs so the recursion can never wrap
  always_comb acc_d = mul(bus.din, B0) + mul(x1_q, B1) + mul(x2_q, B2) - mul(y1_q, A1) - mul(y2_q, A2);
  iir_round_sat u_round_sat (
    .acc_i(acc_d),
    .y_o  (y_d)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q   <= '0;
      x2_q   <= '0;
      y1_q   <= '0;
      y2_q   <= '0;
      dout_q <= '0;
    end else begin
      x1_q   <= bus.din;
      x2_q   <= x1_q;
      y1_q   <= y_d;
      y2_q   <= y1_q;
      dout_q <= y_d;
    end
  end
  assign bus.dout = dout_q;
endmodule

// File: tb/tb_iir_df1_biquad_filter.sv
// tb_iir_df1_biquad_filter: directed vectors checked against an integer difference-equation model.
module tb_iir_df1_biquad_filter;
  import iir_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  iir_df1_biquad_filter_if bus ();
  iir_df1_biquad_filter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  function automatic int model(int d, int x1, int x2, int y1, int y2);
    longint acc, s;
    acc = 64'sd15 * d + 64'sd31 * x1 + 64'sd15 * x2 - (-64'sd31313) * y1 - 64'sd14991 * y2;
    s   = (acc + 64'sd8192) >>> 14;
    return s > 32767 ? 32767 : s < -32768 ? -32768 : int'(s);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx1 <= 0;
      mx2 <= 0;
      my1 <= 0;
      my2 <= 0;
    end else begin
      my1 <= model(int'(bus.din), mx1, mx2, my1, my2);
      my2 <= my1;
      mx1 <= int'(bus.din);
      mx2 <= mx1;
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (cmp_en) chk("model", int'(bus.dout), my1);
  task automatic step(input int v);
    bus.din = sample_t'(v);
    @(negedge clk);
  endtask
  task automatic restart();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  int hi, lo, v;
  real r;
  initial begin
    bus.din = '0;
    repeat (2) @(negedge clk);
    chk("reset_dout", int'(bus.dout), 0);
    cmp_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(i % 2 ? 0 : 12345);
      chk("reset_hold", int'(bus.dout), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("release_zero", int'(bus.dout), 0);
    end
    step(16384);
    chk("impulse0", int'(bus.dout), 15);
    step(0);
    chk("impulse1", int'(bus.dout), 60);
    step(0);
    chk("impulse2", int'(bus.dout), 116);
    repeat (60) step(0);
    restart();
    step(1000);
    chk("first_after_reset", int'(bus.dout), 1);
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      step(1000);
      if (int'(bus.dout) > hi) hi = int'(bus.dout);
    end
    chk("step_overshoot", int'(hi > 984), 1);
    restart();
    hi = 0;
    lo = 0;
    for (int i = 0; i < 400; i++) begin
      step(32767);
      if (int'(bus.dout) > hi) hi = int'(bus.dout);
      if (int'(bus.dout) < lo) lo = int'(bus.dout);
    end
    chk("sat_pos_max", hi, 32767);
    chk("sat_pos_nonneg", lo, 0);
    restart();
    hi = 0;
    lo = 0;
    for (int i = 0; i < 400; i++) begin
      step(-32768);
      if (int'(bus.dout) > hi) hi = int'(bus.dout);
      if (int'(bus.dout) < lo) lo = int'(bus.dout);
    end
    chk("sat_neg_min", lo, -32768);
    chk("sat_neg_nonpos", hi, 0);
    restart();
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      r = 10000.0 * $sin(2.0 * 3.14159265358979 * 0.005 * i) + 3000.0 * $sin(2.0 * 3.14159265358979 * 0.2 * i);
      v = $rtoi(r + (r >= 0.0 ? 0.5 : -0.5));
      step(v);
      if (i == 500) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", int'(bus.dout), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
      end
      if (i >= 750 && int'(bus.dout) > hi) hi = int'(bus.dout);
    end
    chk("sine_amp", int'(hi >= 9000 && hi <= 10500), 1);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
